// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned WIDTHxWIDTH multiply (shift-add) and WIDTH/WIDTH divide
// (restoring) built around a single shared combinational adder. Results land in
// HI/LO and hold until the next accepted start.

// Shared 32-bit combinational adder; the sequencer time-multiplexes its operands.
module adder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result
);
  assign Result = A + B;
endmodule

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_negb;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_rs;
  logic               w_carry;
  logic               w_ok;

  adder32 u_adder (
    .A      (w_add_a),
    .B      (w_add_b),
    .Result (w_sum)
  );

  // Partial remainder shifted left by one, pulling in the next dividend bit.
  assign w_rs = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

  // Carry-out recovered from the operand and sum MSBs so the adder stays WIDTH bits.
  assign w_carry = (w_add_a[WIDTH-1] & w_add_b[WIDTH-1]) |
                   ((w_add_a[WIDTH-1] | w_add_b[WIDTH-1]) & ~w_sum[WIDTH-1]);

  // Subtraction succeeds if the shifted-out remainder bit was set or Rs >= divisor.
  assign w_ok = r_hi[WIDTH-1] | w_carry;

  // Adder operand muxing for the current state and operation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_add_a = '0;
    w_add_b = '0;
    unique case (r_state)
      S_PREP: begin
        if (r_op) begin
          w_add_a = ~r_m;
          w_add_b = WIDTH'(1);
        end
      end
      S_RUN: begin
        if (r_op) begin
          w_add_a = w_rs;
          w_add_b = r_negb;
        end else begin
          w_add_a = r_hi;
          w_add_b = r_lo[0] ? r_m : '0;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (op && (opB == '0)) ? S_DONE : S_PREP;
        end
      end
      S_PREP: w_next = S_RUN;
      S_RUN:  if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath registers: operand capture, negated divisor, iteration steps, counter.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: every datapath register is reset so an abandoned operation leaves no trace.
    if (reset) begin
      r_op   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_m    <= '0;
      r_negb <= '0;
      r_cnt  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_m   <= opB;
            r_dbz <= 1'b0;
            if (op && (opB == '0)) begin
              r_hi  <= opA;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi <= '0;
              r_lo <= opA;
            end
          end
        end
        S_PREP: begin
          r_cnt <= CNT_W'(WIDTH);
          if (r_op) r_negb <= w_sum;
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_op) begin
            r_hi <= w_ok ? w_sum : w_rs;
            r_lo <= {r_lo[WIDTH-2:0], w_ok};
          end else begin
            r_hi <= {w_carry, w_sum[WIDTH-1:1]};
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = r_dbz;
  assign HI          = r_hi;
  assign LO          = r_lo;

endmodule
